// File: rtl/rtc_bus_responder.sv
// RTC-side responder for the multiplexed a_d/cs/rd/wr control bus: 64-byte register
// file, registered read-back, and BCD seconds/minutes/hours advanced by a 1 Hz tick.
module rtc_bus_responder #(
    parameter int unsigned REG_DEPTH = 64,
    parameter logic [7:0]  ADDR_SEC  = 8'h21,
    parameter logic [7:0]  ADDR_MIN  = 8'h22,
    parameter logic [7:0]  ADDR_HOUR = 8'h23,
    parameter logic [7:0]  ADDR_CTRL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic       tick_1hz,
    output logic       bus_err,
    output logic [7:0] addr_q
);

    localparam int AW       = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int SEC_IDX  = int'(ADDR_SEC);
    localparam int MIN_IDX  = int'(ADDR_MIN);
    localparam int HOUR_IDX = int'(ADDR_HOUR);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    state_t      state_q, state_d;
    logic [7:0]  bus_q;
    logic [7:0]  reg_q [REG_DEPTH];
    logic [7:0]  reg_d [REG_DEPTH];

    logic        proto_err;
    logic        addr_commit, wr_commit, wr_en;
    logic [7:0]  addr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [7:0]  rd_data;
    logic [7:0]  ad_out_d;
    logic        ad_oe_d;
    logic        hold, time_wr, tick_en;
    logic [8:0]  sec_inc, min_inc, hour_inc;

    // {carry, next}: max value and any invalid low nibble wrap to 0x00 with carry.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v || v[3:0] > 4'd9)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'h0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: decoded afresh from the bus every cycle
    always_comb begin
        proto_err = !cs && !rd && (!wr || !a_d);
        state_d   = IDLE;
        if (!cs && !proto_err) begin
            if (!wr && rd)
                state_d = a_d ? WDATA : ADDR;
            else if (!rd && wr && a_d)
                state_d = RDATA;
        end
    end

    // Outputs: commits fire when a phase is left without a protocol violation
    always_comb begin
        addr_commit = (state_q == ADDR)  && (state_d != ADDR)  && !proto_err;
        wr_commit   = (state_q == WDATA) && (state_d != WDATA) && !proto_err;
        addr_d      = addr_commit ? bus_q : addr_q;
        wr_en       = wr_commit && (32'(addr_q) < REG_DEPTH);
        wr_idx      = addr_q[AW-1:0];
        rd_idx      = addr_d[AW-1:0];
        rd_data     = 8'h00;
        if (32'(addr_d) < REG_DEPTH)
            rd_data = (wr_en && addr_q == addr_d) ? bus_q : reg_q[rd_idx];
        ad_oe_d     = (state_d == RDATA);
        ad_out_d    = ad_oe_d ? rd_data : ad_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q   <= 8'h00;
            addr_q  <= 8'h00;
            ad_out  <= 8'h00;
            ad_oe   <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            bus_q   <= ad_in;
            addr_q  <= addr_d;
            ad_out  <= ad_out_d;
            ad_oe   <= ad_oe_d;
            bus_err <= proto_err;
        end
    end

    // A bus write to any time register drops the coincident tick for all three.
    always_comb begin
        hold     = reg_q[ADDR_CTRL[AW-1:0]][3];
        time_wr  = wr_en && (addr_q == ADDR_SEC || addr_q == ADDR_MIN || addr_q == ADDR_HOUR);
        tick_en  = tick_1hz && !hold && !time_wr;
        sec_inc  = bcd_inc(reg_q[ADDR_SEC[AW-1:0]],  8'h59);
        min_inc  = bcd_inc(reg_q[ADDR_MIN[AW-1:0]],  8'h59);
        hour_inc = bcd_inc(reg_q[ADDR_HOUR[AW-1:0]], 8'h23);
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(REG_DEPTH); gi++) begin : g_reg
            assign reg_d[gi] =
                (wr_en && wr_idx == AW'(gi))                           ? bus_q          :
                (tick_en && gi == SEC_IDX)                             ? sec_inc[7:0]   :
                (tick_en && gi == MIN_IDX && sec_inc[8])               ? min_inc[7:0]   :
                (tick_en && gi == HOUR_IDX && sec_inc[8] && min_inc[8]) ? hour_inc[7:0] :
                                                                         reg_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_DEPTH); i++)
                reg_q[i] <= 8'h00;
        end else begin
            reg_q <= reg_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed and randomized bus transactions against a byte-array/decimal-arithmetic
// model of the RTC register file and clock.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_d = 1'b0, cs = 1'b1, rd = 1'b1, wr = 1'b1;
    logic [7:0] ad_in = 8'h00;
    logic       tick_1hz = 1'b0;
    logic [7:0] ad_out, addr_q;
    logic       ad_oe, bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    rtc_bus_responder dut (
        .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .tick_1hz(tick_1hz),
        .bus_err(bus_err), .addr_q(addr_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: wait for the falling edge, then drive the inputs for the next rising edge.
    task automatic step(input logic c, input logic ad, input logic r, input logic w,
                        input logic [7:0] d, input logic tk);
        @(negedge clk);
        cs = c; a_d = ad; rd = r; wr = w; ad_in = d; tick_1hz = tk;
    endtask

    function automatic logic [8:0] model_inc(input logic [7:0] v, input int limit);
        int n;
        if (v[3:0] > 4'd9) return 9'h100;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (n == limit) return 9'h100;
        n = n + 1;
        return {1'b0, 4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic model_tick();
        logic [8:0] s, m, h;
        if (mem[8'h00][3]) return;
        s = model_inc(mem[8'h21], 59);
        mem[8'h21] = s[7:0];
        if (s[8]) begin
            m = model_inc(mem[8'h22], 59);
            mem[8'h22] = m[7:0];
            if (m[8]) begin
                h = model_inc(mem[8'h23], 23);
                mem[8'h23] = h[7:0];
            end
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d, input logic tk);
        logic in_range, is_time;
        in_range = (a < 8'd64);
        is_time  = in_range && (a == 8'h21 || a == 8'h22 || a == 8'h23);
        if (tk && !is_time) model_tick();
        if (in_range) mem[a] = d;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic tk);
        step(0, 0, 1, 0, a, 0);
        step(0, 0, 1, 1, a, 0);
        step(0, 1, 1, 0, d, 0);
        step(0, 1, 1, 1, d, tk);
        step(1, 0, 1, 1, 8'h00, 0);
        model_write(a, d, tk);
        $display("write addr=%h data=%h tick=%0d", a, d, tk);
    endtask

    task automatic do_read(input logic [7:0] a, input string tag);
        logic [7:0] exp;
        exp = (a < 8'd64) ? mem[a] : 8'h00;
        step(0, 0, 1, 0, a, 0);
        step(0, 0, 1, 1, a, 0);
        step(0, 1, 0, 1, 8'h00, 0);
        chk({tag, "_oe_pre"}, {7'b0, ad_oe}, 8'h00);
        step(1, 0, 1, 1, 8'h00, 0);
        chk({tag, "_oe"}, {7'b0, ad_oe}, 8'h01);
        chk({tag, "_data"}, ad_out, exp);
        chk({tag, "_addr"}, addr_q, a);
        step(1, 0, 1, 1, 8'h00, 0);
        chk({tag, "_oe_off"}, {7'b0, ad_oe}, 8'h00);
        $display("read  addr=%h data=%h expected=%h", a, ad_out, exp);
    endtask

    task automatic do_tick();
        step(1, 0, 1, 1, 8'h00, 1);
        model_tick();
        step(1, 0, 1, 1, 8'h00, 0);
        $display("tick  sec=%h min=%h hour=%h", mem[8'h21], mem[8'h22], mem[8'h23]);
    endtask

    initial begin
        logic [7:0] a, d;
        int op;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        step(1, 0, 1, 1, 8'h00, 0);
        chk("rst_ad_oe", {7'b0, ad_oe}, 8'h00);
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_bus_err", {7'b0, bus_err}, 8'h00);
        chk("rst_addr_q", addr_q, 8'h00);

        // Write then read-back
        do_write(8'h10, 8'h5A, 0);
        do_read(8'h10, "wr_rd");

        // Read directly after the write phase returns the new value
        step(0, 0, 1, 0, 8'h11, 0);
        step(0, 0, 1, 1, 8'h11, 0);
        step(0, 1, 1, 0, 8'hC3, 0);
        step(0, 1, 0, 1, 8'h00, 0);
        model_write(8'h11, 8'hC3, 0);
        step(1, 0, 1, 1, 8'h00, 0);
        chk("raw_data", ad_out, 8'hC3);
        chk("raw_oe", {7'b0, ad_oe}, 8'h01);
        $display("read-after-write addr=11 data=%h", ad_out);

        // Full rollover chain
        do_write(8'h23, 8'h23, 0);
        do_write(8'h22, 8'h59, 0);
        do_write(8'h21, 8'h59, 0);
        do_tick();
        do_read(8'h21, "roll_sec");
        do_read(8'h22, "roll_min");
        do_read(8'h23, "roll_hour");
        chk("roll_model", mem[8'h23], 8'h00);

        // HOLD freezes counting, ticks are not queued
        do_write(8'h00, 8'h08, 0);
        do_write(8'h21, 8'h12, 0);
        repeat (5) do_tick();
        do_read(8'h21, "hold_sec");
        do_write(8'h00, 8'h00, 0);
        do_tick();
        do_read(8'h21, "unhold_sec");
        chk("unhold_model", mem[8'h21], 8'h13);

        // Tick colliding with a minutes write commit
        do_write(8'h21, 8'h58, 0);
        do_write(8'h22, 8'h30, 1);
        do_read(8'h22, "coll_min");
        do_read(8'h21, "coll_sec");
        // Tick colliding with a non-time write still counts
        do_write(8'h12, 8'h44, 1);
        do_read(8'h21, "coll2_sec");
        do_read(8'h12, "coll2_reg");

        // Protocol error discards the pending write
        step(0, 0, 1, 0, 8'h10, 0);
        step(0, 0, 1, 1, 8'h10, 0);
        step(0, 1, 1, 0, 8'h99, 0);
        step(0, 1, 0, 0, 8'h99, 0);
        step(0, 1, 0, 0, 8'h99, 0);
        chk("err_pulse1", {7'b0, bus_err}, 8'h01);
        chk("err_oe1", {7'b0, ad_oe}, 8'h00);
        step(1, 0, 1, 1, 8'h00, 0);
        chk("err_pulse2", {7'b0, bus_err}, 8'h01);
        chk("err_oe2", {7'b0, ad_oe}, 8'h00);
        step(1, 0, 1, 1, 8'h00, 0);
        chk("err_clear", {7'b0, bus_err}, 8'h00);
        $display("protocol error sequence done");
        do_read(8'h10, "err_reg");

        // Out-of-range address
        do_write(8'h80, 8'h77, 0);
        do_read(8'h80, "oor");

        // Reset during a data phase
        step(0, 0, 1, 0, 8'h05, 0);
        step(0, 0, 1, 1, 8'h05, 0);
        step(0, 1, 1, 0, 8'h33, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 1, 1, 8'h00, 0);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        chk("rst_mid_addr", addr_q, 8'h00);
        $display("reset during write phase");
        do_read(8'h05, "rst_mid_reg");
        do_read(8'h10, "rst_mid_reg10");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            case ($urandom_range(0, 5))
                0:       a = 8'h00;
                1:       a = 8'h21;
                2:       a = 8'h22;
                3:       a = 8'h23;
                4:       a = 8'($urandom_range(64, 255));
                default: a = 8'($urandom_range(0, 63));
            endcase
            if (a == 8'h00)
                d = ($urandom_range(0, 3) == 0) ? 8'h08 : 8'h00;
            else if (a >= 8'h21 && a <= 8'h23)
                d = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            else
                d = 8'($urandom);
            if (op < 4)      do_write(a, d, 1'($urandom_range(0, 1)));
            else if (op < 7) do_read(a, "rnd");
            else             do_tick();
        end
        do_read(8'h21, "final_sec");
        do_read(8'h22, "final_min");
        do_read(8'h23, "final_hour");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
